accelerator_write_weighting: RTL
================================

# accelerator_write_weighting

Computes the DNC write weighting w(t)[i] = gw(t) · (ga(t) · a(t)[i] + (1 − ga(t)) · c(t)[i]) for i = 0..N−1.
- Scalar gates ga (from the allocation gate) and gw (from the write gate) are captured at START.
- Allocation weighting a and content weighting c are pulled element by element from upstream with a request/valid handshake.
- Each w[i] is streamed out with a one-cycle strobe; the consumer is the memory-write / usage stages of the write head.

## Interface
Parameters
- DATA_SIZE, 64, word width of all data ports
- CONTROL_SIZE, 64, width of the length port and index counter
- FRACTION_SIZE, 32, fractional bits of unsigned fixed-point data; ONE = 1 << FRACTION_SIZE

Ports
- CLK  in  1  clock; single clock domain
- RST  in  1  synchronous, active-high reset
- START  in  1  begin a pass; sampled only in IDLE
- READY  out  1  one-cycle pulse when the pass is complete
- GA_IN  in  DATA_SIZE  allocation gate ga, captured at START
- GW_IN  in  DATA_SIZE  write gate gw, captured at START
- SIZE_N_IN  in  CONTROL_SIZE  number of locations N, captured at START
- A_IN_ENABLE  in  1  A_IN valid strobe
- A_IN  in  DATA_SIZE  allocation weighting element a[i]
- A_ENABLE  out  1  one-cycle request for the next a element
- C_IN_ENABLE  in  1  C_IN valid strobe
- C_IN  in  DATA_SIZE  content weighting element c[i]
- C_ENABLE  out  1  one-cycle request for the next c element
- W_OUT_ENABLE  out  1  W_OUT valid strobe, one cycle per element
- W_OUT  out  DATA_SIZE  write weighting element w[i]

## Operation
States and transitions:
- IDLE: on START, capture GA, GW and N, and clear index.
  - If N = 0: go to ENDER.
  - Otherwise: go to REQUEST.
- REQUEST: pulse A_ENABLE and C_ENABLE for one cycle, clear the a/c "got" flags, and go to INPUT.
- INPUT: latch A_IN when A_IN_ENABLE is high and C_IN_ENABLE/C_IN likewise.
  - Strobes may arrive in any order, in the same cycle, or with any gap; waiting is unbounded.
  - A repeated strobe for an element already latched overwrites it.
  - Go to MUL1 when both flags are set, counting a strobe in the current cycle.
- MUL1: register t = (ga·a + (ONE − ga)·c) >> FRACTION_SIZE, using 2·DATA_SIZE-bit intermediates. Go to MUL2.
- MUL2: register w = (gw·t) >> FRACTION_SIZE. Go to OUTPUT.
- OUTPUT: drive W_OUT = w and pulse W_OUT_ENABLE.
  - If index = N−1: go to ENDER.
  - Otherwise: increment index and go to REQUEST.
- ENDER: pulse READY for one cycle and return to IDLE.

Arithmetic and boundary rules:
- Unsigned arithmetic throughout.
- (ONE − ga) wraps modulo 2^DATA_SIZE when ga > ONE, unless saturation is compiled in.
- The result is truncated to the low DATA_SIZE bits.
- START is ignored outside IDLE.
- A_IN_ENABLE and C_IN_ENABLE are ignored outside INPUT.
- RST high in any state forces IDLE and zeroes all registers and outputs; RST wins over a simultaneous START.

## Timing
Reset values:
- READY, A_ENABLE, C_ENABLE, W_OUT_ENABLE = 0.
- W_OUT = 0.
- Index, flags and captured scalars = 0.

Cycle-level timing, with START sampled at edge k:
- A_ENABLE and C_ENABLE are high in cycle k+1.
- Inputs are accepted from cycle k+2 onward.
- If both inputs arrive in cycle m, W_OUT_ENABLE is high in cycle m+3 and W_OUT is valid in that same cycle.
- The next request follows in cycle m+4.
- Minimum element period is 5 cycles.
- READY pulses in the cycle after the last W_OUT_ENABLE.
- With N = 0, READY pulses in cycle k+2 and no other strobe fires.

Output hold and pulse rules:
- W_OUT holds its value until the next OUTPUT state.
- All strobes are exactly one cycle wide.

## Configuration
Macro: ACCELERATOR_WRITE_WEIGHTING_SATURATE_EN.
- Defined:
  - GA and GW are clamped to ONE at capture.
  - t and w are clamped to ONE if the shifted product exceeds ONE or overflows DATA_SIZE.
- Undefined:
  - Raw capture, with wraparound and truncation as described in Operation.
  - No clamp logic is synthesised.

## Test plan
All cases use DATA_SIZE=64, FRACTION_SIZE=32 and ONE=0x1_0000_0000.
- N=1, ga=ONE, gw=ONE, a=0x8000_0000, c=0x4000_0000 -> W_OUT=0x8000_0000; READY exactly one cycle after W_OUT_ENABLE.
- N=1, ga=0, gw=ONE, a=0x8000_0000, c=0x4000_0000 -> W_OUT=0x4000_0000.
- N=4, ga=0x8000_0000, gw=0x8000_0000, a=ONE, c=0 for every element:
  - C strobe arrives 3 cycles after A, then together, then C before A, then A repeated twice.
  - Required: four W_OUT_ENABLE pulses, each W_OUT=0x4000_0000.
  - Required: exactly 4 A_ENABLE and 4 C_ENABLE pulses, and one READY.
- N=0 START -> READY in cycle k+2; no A_ENABLE, C_ENABLE or W_OUT_ENABLE.
- ga=0x2_0000_0000, gw=ONE, a=ONE, c=0:
  - With the macro defined: W_OUT=ONE.
  - Without the macro: W_OUT equals the truncated raw value.
- RST asserted in MUL1 of element 2 of N=4 -> all outputs 0 the next cycle; a fresh START completes a normal pass.

Source files
------------

// File: rtl/accelerator_write_weighting.sv
// DNC write weighting w[i] = gw*(ga*a[i] + (ONE-ga)*c[i]), streamed one element per pass of the FSM.
// Optional clamping of gates and intermediates: ACCELERATOR_WRITE_WEIGHTING_SATURATE_EN.
module accelerator_write_weighting #(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [DATA_SIZE-1:0]    GA_IN,
    input  logic [DATA_SIZE-1:0]    GW_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_N_IN,
    input  logic                    A_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    A_IN,
    output logic                    A_ENABLE,
    input  logic                    C_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    C_IN,
    output logic                    C_ENABLE,
    output logic                    W_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    W_OUT
);
    localparam logic [DATA_SIZE-1:0]   ONE  = {{(DATA_SIZE-1){1'b0}}, 1'b1} << FRACTION_SIZE;
    localparam logic [DATA_SIZE-1:0]   DZ   = '0;

    typedef enum logic [2:0] {
        IDLE, REQUEST, INPUT, MUL1, MUL2, OUTPUT, ENDER
    } state_t;

    state_t                    state_q;
    logic [DATA_SIZE-1:0]      ga_q, gw_q, a_q, c_q, t_q, w_q;
    logic [CONTROL_SIZE-1:0]   n_q, idx_q;
    logic                      got_a_q, got_c_q;
    logic                      ready_q, a_en_q, c_en_q, w_en_q;

    logic [DATA_SIZE-1:0]      one_m_ga, ga_d, gw_d, t_d, w_d;
    logic [2*DATA_SIZE-1:0]    mix, scl;

    always_comb begin
        one_m_ga = ONE - ga_q;
        mix = ({DZ, ga_q} * {DZ, a_q}) + ({DZ, one_m_ga} * {DZ, c_q});
        scl = {DZ, gw_q} * {DZ, t_q};
`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATE_EN
        ga_d = (GA_IN > ONE) ? ONE : GA_IN;
        gw_d = (GW_IN > ONE) ? ONE : GW_IN;
        t_d  = ((mix >> FRACTION_SIZE) > {DZ, ONE}) ? ONE : DATA_SIZE'(mix >> FRACTION_SIZE);
        w_d  = ((scl >> FRACTION_SIZE) > {DZ, ONE}) ? ONE : DATA_SIZE'(scl >> FRACTION_SIZE);
`else
        ga_d = GA_IN;
        gw_d = GW_IN;
        t_d  = DATA_SIZE'(mix >> FRACTION_SIZE);
        w_d  = DATA_SIZE'(scl >> FRACTION_SIZE);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ga_q    <= '0;
            gw_q    <= '0;
            a_q     <= '0;
            c_q     <= '0;
            t_q     <= '0;
            w_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            got_a_q <= 1'b0;
            got_c_q <= 1'b0;
            ready_q <= 1'b0;
            a_en_q  <= 1'b0;
            c_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
        end else begin
            // Strobes are set on the edge entering their state so they line up with it.
            case (state_q)
                IDLE: if (START) begin
                    ga_q  <= ga_d;
                    gw_q  <= gw_d;
                    n_q   <= SIZE_N_IN;
                    idx_q <= '0;
                    if (SIZE_N_IN == '0) begin
                        state_q <= ENDER;
                    end else begin
                        state_q <= REQUEST;
                        a_en_q  <= 1'b1;
                        c_en_q  <= 1'b1;
                    end
                end
                REQUEST: begin
                    a_en_q  <= 1'b0;
                    c_en_q  <= 1'b0;
                    got_a_q <= 1'b0;
                    got_c_q <= 1'b0;
                    state_q <= INPUT;
                end
                INPUT: begin
                    if (A_IN_ENABLE) begin
                        a_q     <= A_IN;
                        got_a_q <= 1'b1;
                    end
                    if (C_IN_ENABLE) begin
                        c_q     <= C_IN;
                        got_c_q <= 1'b1;
                    end
                    if ((got_a_q || A_IN_ENABLE) && (got_c_q || C_IN_ENABLE))
                        state_q <= MUL1;
                end
                MUL1: begin
                    t_q     <= t_d;
                    state_q <= MUL2;
                end
                MUL2: begin
                    w_q     <= w_d;
                    w_en_q  <= 1'b1;
                    state_q <= OUTPUT;
                end
                OUTPUT: begin
                    w_en_q <= 1'b0;
                    if (idx_q == n_q - 1'b1) begin
                        ready_q <= 1'b1;
                        state_q <= ENDER;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        a_en_q  <= 1'b1;
                        c_en_q  <= 1'b1;
                        state_q <= REQUEST;
                    end
                end
                ENDER: begin
                    // An empty pass arrives here with READY low and raises it one cycle later.
                    if (ready_q) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign READY        = ready_q;
    assign A_ENABLE     = a_en_q;
    assign C_ENABLE     = c_en_q;
    assign W_OUT_ENABLE = w_en_q;
    assign W_OUT        = w_q;
endmodule
